e_mdu_param: RTL and testbench

- Parametrised successor to the execute-stage multiply/divide unit of the five-stage MIPS pipeline.
- Holds the HI/LO architectural registers and executes mult/multu/div/divu, madd/maddu/msub/msubu and mthi/mtlo/mfhi/mflo.
- Models multiplier and divider latency through separate programmable countdowns.
- Adds a defined divide-by-zero result, an exception cancel input and an explicit busy output for the hazard unit.

---
 rtl/e_mdu_param_if.sv | 18 +
 rtl/e_mdu_param.sv | 141 ++++++++++++++
 tb/tb_e_mdu_param.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/e_mdu_param_if.sv
// e_mdu_param_if: E-stage multiply/divide request and result bundle between
// the pipeline (master) and the HI/LO unit (slave).
interface e_mdu_param_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] d1;
    logic [WIDTH-1:0] d2;
    logic [3:0]       md_sel;
    logic             md_cancel;
    logic             md_busy;
    logic             md_stall;
    logic [WIDTH-1:0] md_out;

    modport master (output d1, d2, md_sel, md_cancel,
                    input  md_busy, md_stall, md_out);
    modport slave  (input  d1, d2, md_sel, md_cancel,
                    output md_busy, md_stall, md_out);
endinterface

// File: rtl/e_mdu_param.sv
// e_mdu_param: HI/LO multiply/divide unit with programmable mult/div latency,
// exception cancel and an explicit busy flag for the hazard unit.
//
// state | meaning
// IDLE  | accepts start ops and mthi/mtlo
// BUSY  | result parked in hi_temp/lo_temp, counting down to commit
module e_mdu_param #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input logic          clk,
    input logic          reset,
    e_mdu_param_if.slave bus
);
    localparam int MAX_LAT = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW      = $clog2(MAX_LAT + 1);

    localparam logic [3:0] SEL_MULT  = 4'd1;
    localparam logic [3:0] SEL_MULTU = 4'd2;
    localparam logic [3:0] SEL_DIV   = 4'd3;
    localparam logic [3:0] SEL_DIVU  = 4'd4;
    localparam logic [3:0] SEL_MFHI  = 4'd5;
    localparam logic [3:0] SEL_MFLO  = 4'd6;
    localparam logic [3:0] SEL_MTHI  = 4'd7;
    localparam logic [3:0] SEL_MTLO  = 4'd8;
    localparam logic [3:0] SEL_MADD  = 4'd9;
    localparam logic [3:0] SEL_MADDU = 4'd10;
    localparam logic [3:0] SEL_MSUB  = 4'd11;
    localparam logic [3:0] SEL_MSUBU = 4'd12;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t             state;
    logic [WIDTH-1:0]   hi, lo, hi_temp, lo_temp;
    logic [CW-1:0]      count;
    logic               busy;

    logic               start_op, is_div, div_zero, div_ovf;
    logic [CW-1:0]      lat;
    logic [2*WIDTH-1:0] d1_sx, d2_sx, d1_zx, d2_zx;
    logic [2*WIDTH-1:0] prod_s, prod_u, acc, result;
    logic signed [WIDTH-1:0] sd1, sden, squo, srem;
    logic [WIDTH-1:0]   uden, uquo, urem;

    always_comb begin
        start_op = 1'b0;
        case (bus.md_sel)
            SEL_MULT, SEL_MULTU, SEL_DIV, SEL_DIVU,
            SEL_MADD, SEL_MADDU, SEL_MSUB, SEL_MSUBU: start_op = 1'b1;
            default: start_op = 1'b0;
        endcase
        is_div = (bus.md_sel == SEL_DIV) || (bus.md_sel == SEL_DIVU);
        lat    = is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);

        // Sign/zero extension to 2*WIDTH makes a plain multiply exact modulo 2^(2*WIDTH).
        d1_sx  = {{WIDTH{bus.d1[WIDTH-1]}}, bus.d1};
        d2_sx  = {{WIDTH{bus.d2[WIDTH-1]}}, bus.d2};
        d1_zx  = {{WIDTH{1'b0}}, bus.d1};
        d2_zx  = {{WIDTH{1'b0}}, bus.d2};
        prod_s = d1_sx * d2_sx;
        prod_u = d1_zx * d2_zx;
        acc    = {hi, lo};

        // Divisor forced to 1 on zero or overflow: overflow then yields MIN rem 0 directly.
        div_zero = (bus.d2 == '0);
        div_ovf  = (bus.d1 == {1'b1, {(WIDTH-1){1'b0}}}) && (bus.d2 == '1);
        sd1      = bus.d1;
        sden     = (div_zero || div_ovf) ? WIDTH'(1) : bus.d2;
        squo     = sd1 / sden;
        srem     = sd1 % sden;
        uden     = div_zero ? WIDTH'(1) : bus.d2;
        uquo     = bus.d1 / uden;
        urem     = bus.d1 % uden;

        result = '0;
        case (bus.md_sel)
            SEL_MULT:  result = prod_s;
            SEL_MULTU: result = prod_u;
            SEL_DIV:   result = div_zero ? {bus.d1, {WIDTH{1'b1}}} : {srem, squo};
            SEL_DIVU:  result = div_zero ? {bus.d1, {WIDTH{1'b1}}} : {urem, uquo};
            SEL_MADD:  result = acc + prod_s;
            SEL_MADDU: result = acc + prod_u;
            SEL_MSUB:  result = acc - prod_s;
            SEL_MSUBU: result = acc - prod_u;
            default:   result = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            hi      <= '0;
            lo      <= '0;
            hi_temp <= '0;
            lo_temp <= '0;
            count   <= '0;
            busy    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!bus.md_cancel) begin
                        if (bus.md_sel == SEL_MTHI) hi <= bus.d1;
                        if (bus.md_sel == SEL_MTLO) lo <= bus.d1;
                        if (start_op) begin
                            {hi_temp, lo_temp} <= result;
                            count <= lat;
                            state <= BUSY;
                            busy  <= 1'b1;
                        end
                    end
                end
                BUSY: begin
                    // Cancel is checked first so it also wins on the commit edge.
                    if (bus.md_cancel) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        count <= '0;
                    end else if (count == CW'(1)) begin
                        hi    <= hi_temp;
                        lo    <= lo_temp;
                        state <= IDLE;
                        busy  <= 1'b0;
                        count <= '0;
                    end else begin
                        count <= count - CW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.md_busy  = busy;
    assign bus.md_stall = busy | start_op;
    assign bus.md_out   = (bus.md_sel == SEL_MFHI) ? hi :
                          (bus.md_sel == SEL_MFLO) ? lo : '0;
endmodule

// File: tb/tb_e_mdu_param.sv
// tb_e_mdu_param: exercises a 32-bit default instance and a 16-bit fast instance
// with fixed vectors, corner sequences and random ops against an arithmetic model.
module tb_e_mdu_param;
    localparam logic [3:0] OP_NONE  = 4'd0;
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;
    localparam logic [3:0] OP_MADD  = 4'd9;
    localparam logic [3:0] OP_MADDU = 4'd10;
    localparam logic [3:0] OP_MSUB  = 4'd11;
    localparam logic [3:0] OP_MSUBU = 4'd12;

    typedef struct {
        int          tgt;
        logic [3:0]  sel;
        logic [31:0] a;
        logic [31:0] b;
        int          cyc;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst32, rst16;
    int          tgt = 0;
    logic [31:0] d1, d2;
    logic [3:0]  md_sel;
    logic        md_cancel;
    int          total = 0;
    int          bad = 0;
    logic [63:0] hilo [2];
    vec_t        vecs [20];

    e_mdu_param_if #(.WIDTH(32)) if32 ();
    e_mdu_param_if #(.WIDTH(16)) if16 ();

    e_mdu_param #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) u32 (
        .clk(clk), .reset(rst32), .bus(if32.slave));
    e_mdu_param #(.WIDTH(16), .MULT_CYCLES(1), .DIV_CYCLES(3)) u16 (
        .clk(clk), .reset(rst16), .bus(if16.slave));

    assign if32.d1        = d1;
    assign if32.d2        = d2;
    assign if16.d1        = d1[15:0];
    assign if16.d2        = d2[15:0];
    assign if32.md_sel    = (tgt == 0) ? md_sel : OP_NONE;
    assign if16.md_sel    = (tgt == 1) ? md_sel : OP_NONE;
    assign if32.md_cancel = (tgt == 0) ? md_cancel : 1'b0;
    assign if16.md_cancel = (tgt == 1) ? md_cancel : 1'b0;

    wire        busy_o  = (tgt == 1) ? if16.md_busy  : if32.md_busy;
    wire        stall_o = (tgt == 1) ? if16.md_stall : if32.md_stall;
    wire [31:0] out_o   = (tgt == 1) ? {16'h0, if16.md_out} : if32.md_out;

    always #5 clk = ~clk;

    function automatic int width_of(input int t);
        return (t == 1) ? 16 : 32;
    endfunction

    function automatic bit is_start(input logic [3:0] sel);
        return sel inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU,
                           OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU};
    endfunction

    function automatic int lat_of(input int t, input logic [3:0] sel);
        if (!is_start(sel)) return 0;
        if (sel == OP_DIV || sel == OP_DIVU) return (t == 1) ? 3 : 10;
        return (t == 1) ? 1 : 5;
    endfunction

    // Architectural effect of one op on {hi,lo}, using plain 64-bit arithmetic.
    function automatic logic [63:0] ref_op(input int w, input logic [3:0] sel,
                                           input logic [63:0] hl,
                                           input logic [31:0] ai, input logic [31:0] bi);
        logic [63:0] mw, m2, a, b, r;
        longint      sa, sb, q, rm;
        mw = (64'd1 << w) - 64'd1;
        m2 = (w == 32) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (2 * w)) - 64'd1);
        a  = {32'h0, ai} & mw;
        b  = {32'h0, bi} & mw;
        sa = a[w-1] ? longint'(a) - (longint'(1) << w) : longint'(a);
        sb = b[w-1] ? longint'(b) - (longint'(1) << w) : longint'(b);
        r  = hl;
        case (sel)
            OP_MULT:  r = sa * sb;
            OP_MULTU: r = a * b;
            OP_MADD:  r = hl + sa * sb;
            OP_MADDU: r = hl + a * b;
            OP_MSUB:  r = hl - sa * sb;
            OP_MSUBU: r = hl - a * b;
            OP_DIV: begin
                if (b == 0) r = (a << w) | mw;
                else begin
                    q  = sa / sb;
                    rm = sa % sb;
                    r  = ((rm & mw) << w) | (q & mw);
                end
            end
            OP_DIVU:  r = (b == 0) ? ((a << w) | mw) : (((a % b) << w) | (a / b));
            OP_MTHI:  r = (a << w) | (hl & mw);
            OP_MTLO:  r = (hl & ~mw) | a;
            default:  r = hl;
        endcase
        return r & m2;
    endfunction

    function automatic logic [31:0] pick(input int w);
        logic [31:0] m;
        m = (w == 32) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return m;
            2:       return 32'h1 << (w - 1);
            3:       return 32'($urandom_range(0, 9));
            default: return $urandom & m;
        endcase
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic read_check(input string tag, input logic [31:0] eh, input logic [31:0] el);
        md_sel = OP_MFHI;
        #1 check({tag, "_hi"}, 64'(out_o), 64'(eh));
        md_sel = OP_MFLO;
        #1 check({tag, "_lo"}, 64'(out_o), 64'(el));
        md_sel = OP_NONE;
        #1;
    endtask

    // Issue one op; optionally cancel in busy cycle cancel_at and drive
    // unrelated ops during the first two busy cycles. Returns busy cycle count.
    task automatic do_op(input logic [3:0] sel, input logic [31:0] a, input logic [31:0] b,
                         input int cancel_at, input bit junk, output int cyc);
        @(negedge clk);
        d1 = a;
        d2 = b;
        md_sel = sel;
        md_cancel = 1'b0;
        #1 check("stall_issue", 64'(stall_o), 64'(is_start(sel)));
        @(negedge clk);
        md_sel = OP_NONE;
        cyc = 0;
        while (busy_o && cyc < 64) begin
            cyc++;
            md_cancel = (cyc == cancel_at);
            if (junk && cyc == 1) begin
                md_sel = OP_MTLO;
                d1 = 32'h1234;
            end else if (junk && cyc == 2) begin
                md_sel = OP_MULT;
                d1 = 32'd3;
                d2 = 32'd5;
            end else begin
                md_sel = OP_NONE;
            end
            if (cyc == 1) #1 check("stall_busy", 64'(stall_o), 64'd1);
            @(negedge clk);
        end
        md_cancel = 1'b0;
        md_sel = OP_NONE;
    endtask

    task automatic model_op(input logic [3:0] sel, input logic [31:0] a, input logic [31:0] b,
                            input int cancel_at, input bit junk, input string tag);
        int          w, lat, cyc, exp_cyc;
        logic [63:0] nv, mw;
        bit          cancelled;
        w   = width_of(tgt);
        lat = lat_of(tgt, sel);
        nv  = ref_op(w, sel, hilo[tgt], a, b);
        do_op(sel, a, b, cancel_at, junk, cyc);
        cancelled = (cancel_at >= 1) && (cancel_at <= lat);
        exp_cyc   = cancelled ? cancel_at : lat;
        if (!cancelled) hilo[tgt] = nv;
        check({tag, "_cycles"}, 64'(cyc), 64'(exp_cyc));
        mw = (64'd1 << w) - 64'd1;
        read_check(tag, 32'(hilo[tgt] >> w), 32'(hilo[tgt] & mw));
    endtask

    task automatic mid_reset(input string tag);
        @(negedge clk);
        d1 = 32'd5;
        d2 = 32'd6;
        md_sel = OP_MULT;
        @(negedge clk);
        md_sel = OP_NONE;
        check({tag, "_busy_pre"}, 64'(busy_o), 64'd1);
        if (tgt == 0) rst32 = 1'b1;
        else rst16 = 1'b1;
        @(negedge clk);
        rst32 = 1'b0;
        rst16 = 1'b0;
        #1 check({tag, "_busy"}, 64'(busy_o), 64'd0);
        check({tag, "_stall"}, 64'(stall_o), 64'd0);
        read_check(tag, 32'h0, 32'h0);
        hilo[tgt] = 64'h0;
    endtask

    task automatic random_ops(input int n, input string tag);
        logic [3:0] ops [12];
        logic [3:0] sel;
        int         w, cancel_at;
        ops = '{OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MADD, OP_MADDU,
                OP_MSUB, OP_MSUBU, OP_MTHI, OP_MTLO, OP_MFHI, OP_NONE};
        w = width_of(tgt);
        for (int i = 0; i < n; i++) begin
            sel = ops[$urandom_range(0, 11)];
            cancel_at = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 11)) : 0;
            model_op(sel, pick(w), pick(w), cancel_at, bit'($urandom_range(0, 3) == 0),
                     $sformatf("%s%0d", tag, i));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int          cyc, w;
        logic [63:0] keep;

        vecs[0]  = '{0, OP_MULT,  32'hFFFF_FFFE, 32'd3,         5,  32'hFFFF_FFFF, 32'hFFFF_FFFA};
        vecs[1]  = '{0, OP_DIVU,  32'd7,         32'd0,         10, 32'd7,         32'hFFFF_FFFF};
        vecs[2]  = '{0, OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 10, 32'd0,         32'h8000_0000};
        vecs[3]  = '{0, OP_MTHI,  32'd1,         32'd0,         0,  32'd1,         32'h8000_0000};
        vecs[4]  = '{0, OP_MTLO,  32'hFFFF_FFFF, 32'd0,         0,  32'd1,         32'hFFFF_FFFF};
        vecs[5]  = '{0, OP_MADDU, 32'd1,         32'd1,         5,  32'd2,         32'd0};
        vecs[6]  = '{0, OP_MSUB,  32'd1,         32'd3,         5,  32'd1,         32'hFFFF_FFFD};
        vecs[7]  = '{0, OP_DIV,   32'd7,         32'hFFFF_FFFE, 10, 32'd1,         32'hFFFF_FFFD};
        vecs[8]  = '{0, OP_DIV,   32'hFFFF_FFF9, 32'd2,         10, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[9]  = '{0, OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5,  32'hFFFF_FFFE, 32'h0000_0001};
        vecs[10] = '{0, OP_MADD,  32'hFFFF_FFFF, 32'd2,         5,  32'hFFFF_FFFD, 32'hFFFF_FFFF};
        vecs[11] = '{0, OP_MULT,  32'h7FFF_FFFF, 32'h7FFF_FFFF, 5,  32'h3FFF_FFFF, 32'h0000_0001};
        vecs[12] = '{0, 4'd13,    32'd9,         32'd9,         0,  32'h3FFF_FFFF, 32'h0000_0001};
        vecs[13] = '{1, OP_MULT,  32'h0000_FFFE, 32'd3,         1,  32'h0000_FFFF, 32'h0000_FFFA};
        vecs[14] = '{1, OP_DIVU,  32'd7,         32'd0,         3,  32'd7,         32'h0000_FFFF};
        vecs[15] = '{1, OP_DIV,   32'h0000_8000, 32'h0000_FFFF, 3,  32'd0,         32'h0000_8000};
        vecs[16] = '{1, OP_MTHI,  32'd1,         32'd0,         0,  32'd1,         32'h0000_8000};
        vecs[17] = '{1, OP_MTLO,  32'h0000_FFFF, 32'd0,         0,  32'd1,         32'h0000_FFFF};
        vecs[18] = '{1, OP_MADDU, 32'd1,         32'd1,         1,  32'd2,         32'd0};
        vecs[19] = '{1, OP_MSUB,  32'd1,         32'd3,         1,  32'd1,         32'h0000_FFFD};

        rst32 = 1'b1;
        rst16 = 1'b1;
        d1 = '0;
        d2 = '0;
        md_sel = OP_NONE;
        md_cancel = 1'b0;
        hilo[0] = '0;
        hilo[1] = '0;
        repeat (3) @(negedge clk);
        rst32 = 1'b0;
        rst16 = 1'b0;
        for (int t = 0; t < 2; t++) begin
            tgt = t;
            #1 check($sformatf("reset_busy_t%0d", t), 64'(busy_o), 64'd0);
            check($sformatf("reset_stall_t%0d", t), 64'(stall_o), 64'd0);
            read_check($sformatf("reset_t%0d", t), 32'h0, 32'h0);
        end

        for (int i = 0; i < 20; i++) begin
            tgt = vecs[i].tgt;
            w = width_of(tgt);
            do_op(vecs[i].sel, vecs[i].a, vecs[i].b, 0, 1'b0, cyc);
            check($sformatf("vec%0d_cycles", i), 64'(cyc), 64'(vecs[i].cyc));
            read_check($sformatf("vec%0d", i), vecs[i].hi, vecs[i].lo);
            hilo[tgt] = (64'(vecs[i].hi) << w) | 64'(vecs[i].lo);
        end

        tgt = 0;
        md_sel = OP_NONE;
        #1 check("out_sel_none", 64'(out_o), 64'd0);
        md_sel = 4'd14;
        #1 check("out_sel_14", 64'(out_o), 64'd0);
        md_sel = OP_NONE;

        // Cancel in IDLE suppresses a start op and an mtlo, yet stall still follows md_sel.
        keep = hilo[0];
        @(negedge clk);
        d1 = 32'd5;
        d2 = 32'd7;
        md_sel = OP_MULT;
        md_cancel = 1'b1;
        #1 check("stall_with_cancel", 64'(stall_o), 64'd1);
        @(negedge clk);
        md_sel = OP_MTLO;
        d1 = 32'hABCD;
        check("busy_idle_cancel", 64'(busy_o), 64'd0);
        @(negedge clk);
        md_sel = OP_NONE;
        md_cancel = 1'b0;
        read_check("idle_cancel", 32'(keep >> 32), 32'(keep));

        model_op(OP_DIV, 32'd100, 32'd7, 4, 1'b0, "cancel_busy4");
        model_op(OP_DIV, 32'd100, 32'd7, 10, 1'b0, "cancel_commit");
        model_op(OP_DIV, 32'd100, 32'd7, 0, 1'b0, "div_after_cancel");
        model_op(OP_MULTU, 32'd6, 32'd7, 0, 1'b1, "busy_ignore");
        mid_reset("midrst32");
        random_ops(60, "rnd32_");

        tgt = 1;
        model_op(OP_DIV, 32'd50, 32'd3, 3, 1'b0, "cancel_commit16");
        model_op(OP_DIV, 32'd50, 32'd3, 1, 1'b0, "cancel_first16");
        model_op(OP_DIV, 32'd50, 32'd3, 0, 1'b0, "div16");
        model_op(OP_MULT, 32'h0000_1234, 32'd2, 0, 1'b1, "busy_ignore16");
        random_ops(60, "rnd16_");
        mid_reset("midrst16");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
